// File: rtl/dsp_mac_pkg.sv
// Shared definitions for the streaming pre-add / multiply / post-add engine:
// mode encodings, per-beat control bundle, saturation limits and width check.
package dsp_mac_pkg;

  localparam logic [1:0] MUL   = 2'b00;
  localparam logic [1:0] MAC   = 2'b01;
  localparam logic [1:0] MSUB  = 2'b10;
  localparam logic [1:0] ACC_C = 2'b11;

  localparam int SAT_MAX_W = 128;

  typedef struct packed {
    logic [1:0] mode;
    logic       carryin;
    logic       pre_sel;
    logic       pre_sub;
    logic       last;
  } beat_ctrl_t;

  // Largest positive (negative=0) or most negative (negative=1) value of a
  // width-bit two's complement number, returned zero-extended.
  function automatic logic [SAT_MAX_W-1:0] sat_limit(input int unsigned width,
                                                     input logic negative);
    logic [SAT_MAX_W-1:0] msb;
    msb = SAT_MAX_W'(1) << (width - 1);
    return negative ? msb : msb - SAT_MAX_W'(1);
  endfunction

  function automatic bit widths_ok(input int a_w, input int b_w, input int p_w);
    return p_w >= a_w + b_w + 1;
  endfunction

endpackage

// File: rtl/dsp_mac_postadd.sv
// Final stage: post-adder with carry/overflow, optional clamping, the burst
// accumulator with its sticky overflow flag, and the output (P) register.
module dsp_mac_postadd
  import dsp_mac_pkg::*;
#(
  parameter int P_W      = 48,
  parameter bit SATURATE = 1'b0
) (
  input  logic           clk,
  input  logic           rst_n,
  input  logic           adv,
  input  logic           beat_valid,
  input  logic [1:0]     mode,
  input  logic           carryin,
  input  logic           last,
  input  logic [P_W-1:0] m,
  input  logic [P_W-1:0] c,
  output logic [P_W-1:0] p,
  output logic           carryout,
  output logic           ovf,
  output logic           out_valid,
  output logic           out_last
);

  localparam logic [P_W-1:0] SAT_MAX = P_W'(sat_limit(P_W, 1'b0));
  localparam logic [P_W-1:0] SAT_MIN = P_W'(sat_limit(P_W, 1'b1));

  logic [P_W-1:0] acc_reg;
  logic           sticky_reg;
  logic [P_W-1:0] op1, op2, res;
  logic [P_W:0]   sum;
  logic           cin, is_acc, ovf_now, ovf_tot;

  always_comb begin
    is_acc = (mode == MAC) || (mode == ACC_C);
    op1    = is_acc ? acc_reg : c;
    case (mode)
      MUL, MAC: op2 = m;
      MSUB:     op2 = ~m;
      default:  op2 = c;
    endcase
    // MSUB is C + ~M + !CARRYIN, i.e. a borrow-style subtract
    cin     = (mode == MSUB) ? !carryin : carryin;
    sum     = {1'b0, op1} + {1'b0, op2} + {{P_W{1'b0}}, cin};
    ovf_now = (op1[P_W-1] == op2[P_W-1]) && (sum[P_W-1] != op1[P_W-1]);
    res     = sum[P_W-1:0];
    if (SATURATE && ovf_now) begin
      res = op1[P_W-1] ? SAT_MIN : SAT_MAX;
    end
    ovf_tot = ovf_now | (is_acc & sticky_reg);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      acc_reg    <= '0;
      sticky_reg <= 1'b0;
      p          <= '0;
      carryout   <= 1'b0;
      ovf        <= 1'b0;
      out_valid  <= 1'b0;
      out_last   <= 1'b0;
    end else if (adv) begin
      out_valid <= 1'b0;
      if (beat_valid) begin
        if (is_acc && !last) begin
          // mid-burst beat: fold into the accumulator, nothing emitted
          acc_reg    <= res;
          sticky_reg <= ovf_tot;
        end else begin
          out_valid <= 1'b1;
          p         <= res;
          carryout  <= sum[P_W];
          ovf       <= ovf_tot;
          out_last  <= last;
          if (is_acc) begin
            acc_reg    <= '0;
            sticky_reg <= 1'b0;
          end
        end
      end
    end
  end

endmodule

// File: rtl/dsp_mac_pipe.sv
// Four-stage streaming MAC: input reg -> pre-add reg -> multiply reg -> P reg,
// the whole pipe stalling together under output backpressure.
module dsp_mac_pipe
  import dsp_mac_pkg::*;
#(
  parameter int A_W      = 18,
  parameter int B_W      = 18,
  parameter int P_W      = 48,
  parameter bit SATURATE = 1'b0
) (
  input  logic           clk,
  input  logic           rst_n,
  input  logic [A_W-1:0] a,
  input  logic [B_W-1:0] b,
  input  logic [B_W-1:0] d,
  input  logic [P_W-1:0] c,
  input  logic           carryin,
  input  logic           pre_sel,
  input  logic           pre_sub,
  input  logic [1:0]     mode,
  input  logic           in_valid,
  input  logic           in_last,
  output logic           in_ready,
  output logic [P_W-1:0] p,
  output logic           carryout,
  output logic           ovf,
  output logic           out_valid,
  output logic           out_last,
  input  logic           out_ready
);

  localparam int XW = B_W + 1;
  localparam int MW = A_W + B_W + 1;

  if (!widths_ok(A_W, B_W, P_W)) begin : g_width_check
    $error("dsp_mac_pipe: P_W must be at least A_W+B_W+1");
  end

  logic run_reg;
  logic adv;

  assign adv      = !out_valid | out_ready;
  assign in_ready = run_reg & adv;

  logic signed [A_W-1:0] a1_reg, a2_reg;
  logic signed [B_W-1:0] b1_reg, d1_reg;
  logic signed [XW-1:0]  x2_reg, pre_sum, x_sel;
  logic signed [MW-1:0]  prod;
  logic signed [P_W-1:0] m3_reg;

  // C, control and valid travel alongside the datapath through stages 1..3
  logic [P_W-1:0] c_reg     [3];
  beat_ctrl_t     ctrl_reg  [3];
  logic           valid_reg [3];

  genvar gi;
  for (gi = 0; gi < 3; gi++) begin : g_side
    logic [P_W-1:0] c_src;
    beat_ctrl_t     ctrl_src;
    logic           valid_src;
    if (gi == 0) begin : g_head
      assign c_src     = c;
      assign ctrl_src  = {mode, carryin, pre_sel, pre_sub, in_last};
      assign valid_src = in_valid & in_ready;
    end else begin : g_tail
      assign c_src     = c_reg[gi-1];
      assign ctrl_src  = ctrl_reg[gi-1];
      assign valid_src = valid_reg[gi-1];
    end
    always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
        c_reg[gi]     <= '0;
        ctrl_reg[gi]  <= '0;
        valid_reg[gi] <= 1'b0;
      end else if (adv) begin
        c_reg[gi]     <= c_src;
        ctrl_reg[gi]  <= ctrl_src;
        valid_reg[gi] <= valid_src;
      end
    end
  end

  always_comb begin
    pre_sum = ctrl_reg[0].pre_sub ? (XW'(d1_reg) - XW'(b1_reg))
                                  : (XW'(d1_reg) + XW'(b1_reg));
    x_sel   = ctrl_reg[0].pre_sel ? pre_sum : XW'(b1_reg);
  end

  assign prod = MW'(a2_reg) * MW'(x2_reg);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      run_reg <= 1'b0;
      a1_reg  <= '0;
      b1_reg  <= '0;
      d1_reg  <= '0;
      a2_reg  <= '0;
      x2_reg  <= '0;
      m3_reg  <= '0;
    end else begin
      run_reg <= 1'b1;
      if (adv) begin
        a1_reg <= a;
        b1_reg <= b;
        d1_reg <= d;
        a2_reg <= a1_reg;
        x2_reg <= x_sel;
        m3_reg <= P_W'(prod);
      end
    end
  end

  dsp_mac_postadd #(
    .P_W      (P_W),
    .SATURATE (SATURATE)
  ) u_postadd (
    .clk        (clk),
    .rst_n      (rst_n),
    .adv        (adv),
    .beat_valid (valid_reg[2]),
    .mode       (ctrl_reg[2].mode),
    .carryin    (ctrl_reg[2].carryin),
    .last       (ctrl_reg[2].last),
    .m          (m3_reg),
    .c          (c_reg[2]),
    .p          (p),
    .carryout   (carryout),
    .ovf        (ovf),
    .out_valid  (out_valid),
    .out_last   (out_last)
  );

endmodule

// File: tb/tb_dsp_mac_pipe.sv
// Scoreboard bench: a wrapping and a saturating instance share one stimulus
// stream; expected results are queued at accept time and popped on output.
`timescale 1ns/1ps
module tb_dsp_mac_pipe;
  import dsp_mac_pkg::*;

  localparam longint PMAX = 64'sh0000_7FFF_FFFF_FFFF;
  localparam longint PMIN = -PMAX - 64'sd1;

  logic               clk, rst_n;
  logic signed [17:0] a, b, d;
  logic [47:0]        c;
  logic               carryin, pre_sel, pre_sub, in_valid, in_last, out_ready;
  logic [1:0]         mode;

  logic        w_in_ready, w_cout, w_ovf, w_out_valid, w_out_last;
  logic        s_in_ready, s_cout, s_ovf, s_out_valid, s_out_last;
  logic [47:0] w_p, s_p;

  typedef struct {
    logic [47:0] p [2];
    logic        cy [2];
    logic        ov [2];
    logic        last;
  } exp_t;

  exp_t   q[$];
  exp_t   dir_exp;
  bit     dir_use;
  longint acc [2];
  bit     sticky [2];
  int     checks, errors, n_out;
  bit     bp_watch, saw_stall, rand_done;

  dsp_mac_pipe #(.A_W(18), .B_W(18), .P_W(48), .SATURATE(1'b0)) u_wrap (
    .clk(clk), .rst_n(rst_n), .a(a), .b(b), .d(d), .c(c), .carryin(carryin),
    .pre_sel(pre_sel), .pre_sub(pre_sub), .mode(mode), .in_valid(in_valid),
    .in_last(in_last), .in_ready(w_in_ready), .p(w_p), .carryout(w_cout),
    .ovf(w_ovf), .out_valid(w_out_valid), .out_last(w_out_last), .out_ready(out_ready));

  dsp_mac_pipe #(.A_W(18), .B_W(18), .P_W(48), .SATURATE(1'b1)) u_sat (
    .clk(clk), .rst_n(rst_n), .a(a), .b(b), .d(d), .c(c), .carryin(carryin),
    .pre_sel(pre_sel), .pre_sub(pre_sub), .mode(mode), .in_valid(in_valid),
    .in_last(in_last), .in_ready(s_in_ready), .p(s_p), .carryout(s_cout),
    .ovf(s_ovf), .out_valid(s_out_valid), .out_last(s_out_last), .out_ready(out_ready));

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic set_dir(input logic [47:0] p0, input logic [47:0] p1, input logic cy,
                         input logic ov, input logic last);
    dir_exp.p[0] = p0;  dir_exp.p[1] = p1;
    dir_exp.cy[0] = cy; dir_exp.cy[1] = cy;
    dir_exp.ov[0] = ov; dir_exp.ov[1] = ov;
    dir_exp.last = last;
    dir_use = 1'b1;
  endtask

  // Reference arithmetic on true signed values; called as a beat is accepted.
  task automatic model_beat();
    longint      av, bv, dv, cv, pre, x, m, tru;
    logic [47:0] m48, c48, acc48, pv;
    logic [48:0] pat;
    bit          is_acc, ovn, ovr;
    exp_t        e;
    av = longint'(a); bv = longint'(b); dv = longint'(d);
    cv = longint'($signed(c));
    pre = pre_sub ? dv - bv : dv + bv;
    x = pre_sel ? pre : bv;
    m = av * x;
    m48 = m[47:0];
    c48 = c;
    is_acc = (mode == MAC) || (mode == ACC_C);
    for (int s = 0; s < 2; s++) begin
      acc48 = acc[s][47:0];
      case (mode)
        MUL: begin
          tru = cv + m + longint'(carryin);
          pat = {1'b0, c48} + {1'b0, m48} + 49'(carryin);
        end
        MSUB: begin
          tru = cv - m - longint'(carryin);
          pat = {1'b0, c48} + {1'b0, ~m48} + 49'(!carryin);
        end
        MAC: begin
          tru = acc[s] + m + longint'(carryin);
          pat = {1'b0, acc48} + {1'b0, m48} + 49'(carryin);
        end
        default: begin
          tru = acc[s] + cv + longint'(carryin);
          pat = {1'b0, acc48} + {1'b0, c48} + 49'(carryin);
        end
      endcase
      ovn = (tru > PMAX) || (tru < PMIN);
      pv = (s == 1 && ovn) ? ((tru > 0) ? 48'h7FFF_FFFF_FFFF : 48'h8000_0000_0000) : tru[47:0];
      ovr = ovn | (is_acc & sticky[s]);
      if (is_acc && !in_last) begin
        acc[s] = longint'($signed(pv));
        sticky[s] = ovr;
      end else begin
        e.p[s] = pv; e.cy[s] = pat[48]; e.ov[s] = ovr;
        if (is_acc) begin
          acc[s] = 0;
          sticky[s] = 1'b0;
        end
      end
    end
    e.last = in_last;
    if (!is_acc || in_last) begin
      if (dir_use) e = dir_exp;
      q.push_back(e);
    end
    dir_use = 1'b0;
  endtask

  task automatic send_beat(input logic signed [17:0] ta, input logic signed [17:0] tb,
                           input logic signed [17:0] td, input logic [47:0] tc,
                           input logic tcin, input logic tsel, input logic tsub,
                           input logic [1:0] tmode, input logic tlast);
    int n;
    bit done;
    a = ta; b = tb; d = td; c = tc; carryin = tcin; pre_sel = tsel; pre_sub = tsub;
    mode = tmode; in_last = tlast; in_valid = 1'b1;
    n = 0; done = 1'b0;
    while (!done && n < 200) begin
      @(negedge clk);
      if (w_in_ready) begin
        model_beat();
        done = 1'b1;
      end
      @(posedge clk); #1;
      n++;
    end
    if (!done) check("accept_timeout", 64'(w_in_ready), 1);
    in_valid = 1'b0;
  endtask

  task automatic drain();
    int n;
    n = 0;
    while (q.size() != 0 && n < 300) begin
      @(posedge clk);
      n++;
    end
    #1;
    check("drain_empty", 64'(q.size()), 0);
  endtask

  always @(negedge clk) begin
    if (rst_n && w_out_valid) begin
      if (q.size() == 0) begin
        check("spurious_out", 64'(w_out_valid), 0);
      end else begin
        check("p_wrap", 64'(w_p), 64'(q[0].p[0]));
        check("p_sat", 64'(s_p), 64'(q[0].p[1]));
        check("cout_wrap", 64'(w_cout), 64'(q[0].cy[0]));
        check("cout_sat", 64'(s_cout), 64'(q[0].cy[1]));
        check("ovf_wrap", 64'(w_ovf), 64'(q[0].ov[0]));
        check("ovf_sat", 64'(s_ovf), 64'(q[0].ov[1]));
        check("last_wrap", 64'(w_out_last), 64'(q[0].last));
        check("last_sat", 64'(s_out_last), 64'(q[0].last));
        check("valid_sat", 64'(s_out_valid), 1);
        if (out_ready) begin
          void'(q.pop_front());
          n_out++;
        end
      end
    end
    if (rst_n && bp_watch && !w_in_ready) saw_stall = 1'b1;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish, pending %0d", q.size());
    $fatal(1, "watchdog");
  end

  initial begin
    int n, n_before;
    logic signed [17:0] ra, rb, rd;
    logic [1:0] rm;
    logic rl;
    checks = 0; errors = 0; n_out = 0; dir_use = 1'b0;
    bp_watch = 1'b0; saw_stall = 1'b0; rand_done = 1'b0;
    acc[0] = 0; acc[1] = 0; sticky[0] = 1'b0; sticky[1] = 1'b0;
    rst_n = 1'b0; in_valid = 1'b0; in_last = 1'b0; out_ready = 1'b1;
    a = '0; b = '0; d = '0; c = '0; carryin = 1'b0; pre_sel = 1'b0; pre_sub = 1'b0; mode = MUL;

    #13;
    check("rst_out_valid", 64'(w_out_valid), 0);
    check("rst_p", 64'(w_p), 0);
    check("rst_in_ready", 64'(w_in_ready), 0);
    check("rst_ovf", 64'(s_ovf), 0);
    @(negedge clk); rst_n = 1'b1;
    #1 check("rdy_before_edge", 64'(w_in_ready), 0);
    @(posedge clk); #1;
    check("rdy_after_edge", 64'(w_in_ready), 1);

    // MUL through the pre-adder: (25+10)*20 + 350
    set_dir(48'd1050, 48'd1050, 1'b0, 1'b0, 1'b0);
    send_beat(18'sd20, 18'sd10, 18'sd25, 48'd350, 1'b0, 1'b1, 1'b0, MUL, 1'b0);
    drain();

    // MAC burst then a fresh burst starting from zero
    for (int i = 1; i <= 3; i++)
      send_beat(18'(i), 18'sd5, 18'sd0, 48'd0, 1'b0, 1'b0, 1'b0, MAC, 1'b0);
    set_dir(48'd50, 48'd50, 1'b0, 1'b0, 1'b1);
    send_beat(18'sd4, 18'sd5, 18'sd0, 48'd0, 1'b0, 1'b0, 1'b0, MAC, 1'b1);
    send_beat(18'sd2, 18'sd7, 18'sd0, 48'd0, 1'b0, 1'b0, 1'b0, MAC, 1'b0);
    set_dir(48'd21, 48'd21, 1'b0, 1'b0, 1'b1);
    send_beat(18'sd1, 18'sd7, 18'sd0, 48'd0, 1'b0, 1'b0, 1'b0, MAC, 1'b1);
    drain();

    // MSUB with borrow: 100 - 12 - 1
    set_dir(48'd87, 48'd87, 1'b1, 1'b0, 1'b0);
    send_beat(18'sd3, 18'sd4, 18'sd0, 48'd100, 1'b1, 1'b0, 1'b0, MSUB, 1'b0);
    drain();

    // ACC_C overflow: wrap vs clamp
    send_beat(18'sd0, 18'sd0, 18'sd0, 48'h7FFF_FFFF_FFFF, 1'b0, 1'b0, 1'b0, ACC_C, 1'b0);
    set_dir(48'hFFFF_FFFF_FFFE, 48'h7FFF_FFFF_FFFF, 1'b0, 1'b1, 1'b1);
    send_beat(18'sd0, 18'sd0, 18'sd0, 48'h7FFF_FFFF_FFFF, 1'b0, 1'b0, 1'b0, ACC_C, 1'b1);
    drain();

    // Backpressure: 10 MUL beats, OUT_READY low for 5 cycles once results appear
    n_before = n_out; saw_stall = 1'b0; bp_watch = 1'b1;
    fork
      begin
        for (int i = 0; i < 10; i++)
          send_beat(18'(i * 7 - 20), 18'(3 + i), 18'(i), 48'(1000 * i), 1'(i % 2),
                    1'(i % 3 == 0), 1'(i % 2), MUL, 1'b0);
      end
      begin
        out_ready = 1'b0;
        n = 0;
        while (!w_out_valid && n < 50) begin @(negedge clk); n++; end
        repeat (5) @(posedge clk);
        #1 out_ready = 1'b1;
      end
    join
    drain();
    bp_watch = 1'b0;
    check("bp_stall_seen", 64'(saw_stall), 1);
    check("bp_result_count", 64'(n_out - n_before), 10);

    // Asynchronous reset in the middle of a MAC burst with a result held
    out_ready = 1'b0;
    send_beat(18'sd1, 18'sd1, 18'sd0, 48'd5, 1'b0, 1'b0, 1'b0, MUL, 1'b0);
    send_beat(18'sd3, 18'sd3, 18'sd0, 48'd0, 1'b0, 1'b0, 1'b0, MAC, 1'b0);
    send_beat(18'sd3, 18'sd3, 18'sd0, 48'd0, 1'b0, 1'b0, 1'b0, MAC, 1'b0);
    repeat (4) @(posedge clk);
    #2 check("pre_rst_valid", 64'(w_out_valid), 1);
    rst_n = 1'b0;
    #1;
    check("arst_out_valid", 64'(w_out_valid), 0);
    check("arst_p", 64'(w_p), 0);
    check("arst_cout", 64'(w_cout), 0);
    check("arst_ovf", 64'(w_ovf), 0);
    check("arst_out_last", 64'(w_out_last), 0);
    check("arst_in_ready", 64'(w_in_ready), 0);
    q.delete();
    acc[0] = 0; acc[1] = 0; sticky[0] = 1'b0; sticky[1] = 1'b0;
    repeat (2) @(negedge clk);
    rst_n = 1'b1; out_ready = 1'b1;
    @(posedge clk); #1;
    send_beat(18'sd2, 18'sd3, 18'sd0, 48'd0, 1'b0, 1'b0, 1'b0, MAC, 1'b0);
    set_dir(48'd12, 48'd12, 1'b0, 1'b0, 1'b1);
    send_beat(18'sd2, 18'sd3, 18'sd0, 48'd0, 1'b0, 1'b0, 1'b0, MAC, 1'b1);
    drain();

    // Random mixed traffic under random backpressure
    fork
      begin
        for (int i = 0; i < 40; i++) begin
          ra = 18'($urandom); rb = 18'($urandom); rd = 18'($urandom);
          rm = 2'($urandom_range(0, 3));
          rl = (rm == MAC || rm == ACC_C) ? ($urandom_range(0, 2) == 0) : 1'($urandom_range(0, 1));
          if (i == 39) begin rm = MAC; rl = 1'b1; end
          send_beat(ra, rb, rd, 48'({$urandom(), $urandom()}), 1'($urandom_range(0, 1)),
                    1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), rm, rl);
        end
        rand_done = 1'b1;
      end
      begin
        while (!rand_done) begin
          @(posedge clk); #1;
          out_ready = ($urandom_range(0, 3) != 0);
        end
      end
    join
    out_ready = 1'b1;
    drain();

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
